// File: rtl/axis_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_pkg
// Shared definitions for the single-clock AXI4-Stream FIFO.
//   DEFAULT_DEPTH / DEFAULT_DATA_WIDTH : parameter defaults of axis_sync_fifo
//   ptr_width(depth)                   : read/write pointer width (address + wrap bit)
//   is_pow2(n)                         : true for powers of two that are >= 2
// -----------------------------------------------------------------------------
package axis_sync_fifo_pkg;

    localparam int DEFAULT_DEPTH      = 4096;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // One extra bit beyond the RAM address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_ram
// Simple dual-port RAM: one write port, one synchronous read port.
// The read data register doubles as the FIFO output stage, so it carries a
// read enable (hold while stalled) and a synchronous reset; the array itself
// is never reset so that it maps onto block RAM.
// Ports:
//   clk      : clock, rising edge
//   rstn     : synchronous active-low reset of the read data register
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load rd_data from mem[rd_addr] at the next edge
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module axis_sync_fifo_ram
    import axis_sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = ptr_width(DEPTH) - 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock AXI4-Stream FIFO: block RAM plus one registered output stage
// (first-word-fall-through). Capacity is DEPTH words in RAM + 1 in the stage.
// Optional build macro: AXIS_SYNC_FIFO_STATUS_EN adds status_count,
// status_overflow and status_underflow outputs.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   s_axis_t{data,keep,last,user,valid} / s_axis_tready : upstream (write) side
//   m_axis_t{data,keep,last,user,valid} / m_axis_tready : downstream (read) side
//   status_count      (macro) : words held in RAM plus output stage
//   status_overflow   (macro) : pulse after a write attempt while not ready
//   status_underflow  (macro) : pulse after a read attempt while not valid
// -----------------------------------------------------------------------------
module axis_sync_fifo
    import axis_sync_fifo_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 1,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef AXIS_SYNC_FIFO_STATUS_EN
    ,
    output logic [ptr_width(DEPTH):0] status_count,
    output logic                      status_overflow,
    output logic                      status_underflow
`endif
);

    localparam int ADDR_WIDTH = ptr_width(DEPTH) - 1;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    // Only enabled sideband fields occupy RAM columns.
    localparam int KW        = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 0;
    localparam int LW        = (LAST_ENABLE != 0) ? 1 : 0;
    localparam int UW        = (USER_ENABLE != 0) ? USER_WIDTH : 0;
    localparam int KEEP_OFF  = DATA_WIDTH;
    localparam int LAST_OFF  = KEEP_OFF + KW;
    localparam int USER_OFF  = LAST_OFF + LW;
    localparam int RAM_WIDTH = USER_OFF + UW;

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("axis_sync_fifo: DEPTH (%0d) must be a power of two >= 2", DEPTH);
    end

    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 full, ram_empty, wr_en, rd_en;
    wire  [RAM_WIDTH-1:0] wr_word;
    logic [RAM_WIDTH-1:0] rd_word;

    // Disabled sideband inputs are deliberately dropped.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tuser};

    // Same address, opposite wrap bit: RAM holds DEPTH words.
    assign full      = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {ADDR_WIDTH{1'b0}}};
    assign ram_empty = (wr_ptr_reg == rd_ptr_reg);

    assign s_axis_tready = !full;
    assign wr_en         = s_axis_tvalid && !full;
    // Refill the output stage when it is empty or being drained this cycle.
    assign rd_en         = !ram_empty && (!out_valid_reg || m_axis_tready);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + {{ADDR_WIDTH{1'b0}}, wr_en};
        rd_ptr_next    = rd_ptr_reg + {{ADDR_WIDTH{1'b0}}, rd_en};
        out_valid_next = out_valid_reg;
        if (rd_en) begin
            out_valid_next = 1'b1;
        end else if (m_axis_tready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Pack / unpack the stored word.
    assign wr_word[DATA_WIDTH-1:0] = s_axis_tdata;
    assign m_axis_tdata            = rd_word[DATA_WIDTH-1:0];

    if (KEEP_ENABLE != 0) begin : g_keep
        assign wr_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep = rd_word[KEEP_OFF +: KEEP_WIDTH];
    end else begin : g_no_keep
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign wr_word[LAST_OFF] = s_axis_tlast;
        assign m_axis_tlast      = rd_word[LAST_OFF];
    end else begin : g_no_last
        assign m_axis_tlast = 1'b1;
    end

    if (USER_ENABLE != 0) begin : g_user
        assign wr_word[USER_OFF +: USER_WIDTH] = s_axis_tuser;
        assign m_axis_tuser = rd_word[USER_OFF +: USER_WIDTH];
    end else begin : g_no_user
        assign m_axis_tuser = '0;
    end

    assign m_axis_tvalid = out_valid_reg;

    // The RAM read register is the output stage.
    axis_sync_fifo_ram #(
        .WIDTH      (RAM_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

`ifdef AXIS_SYNC_FIFO_STATUS_EN
    logic overflow_reg, underflow_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= s_axis_tvalid && full;
            underflow_reg <= m_axis_tready && !out_valid_reg;
        end
    end

    assign status_count     = {1'b0, wr_ptr_reg - rd_ptr_reg} + {{PTR_WIDTH{1'b0}}, out_valid_reg};
    assign status_overflow  = overflow_reg;
    assign status_underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo
// Self-checking bench for axis_sync_fifo (DEPTH=16, DATA_WIDTH=32), plus a
// second small instance with all sideband disabled sharing the same inputs.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo;

    logic        clk;
    logic        rstn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;

    logic        s_tready2;
    logic [31:0] m_tdata2;
    logic [3:0]  m_tkeep2;
    logic        m_tlast2;
    logic [0:0]  m_tuser2;
    logic        m_tvalid2;

`ifdef AXIS_SYNC_FIFO_STATUS_EN
    logic [5:0] status_count;
    logic       status_overflow, status_underflow;
    logic [3:0] status_count2;
    logic       status_overflow2, status_underflow2;
`endif

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axis_sync_fifo #(
        .DEPTH      (16),
        .DATA_WIDTH (32)
    ) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
`ifdef AXIS_SYNC_FIFO_STATUS_EN
        ,
        .status_count     (status_count),
        .status_overflow  (status_overflow),
        .status_underflow (status_underflow)
`endif
    );

    axis_sync_fifo #(
        .DEPTH       (4),
        .DATA_WIDTH  (32),
        .KEEP_ENABLE (0),
        .LAST_ENABLE (0),
        .USER_ENABLE (0)
    ) u_min (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready2),
        .m_axis_tdata  (m_tdata2),
        .m_axis_tkeep  (m_tkeep2),
        .m_axis_tlast  (m_tlast2),
        .m_axis_tuser  (m_tuser2),
        .m_axis_tvalid (m_tvalid2),
        .m_axis_tready (m_tready)
`ifdef AXIS_SYNC_FIFO_STATUS_EN
        ,
        .status_count     (status_count2),
        .status_overflow  (status_overflow2),
        .status_underflow (status_underflow2)
`endif
    );

    typedef struct {
        logic        rstn;
        logic        sv;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic        chk;
        logic [31:0] e_d;
        logic [3:0]  e_k;
        logic        e_l;
        logic        e_u;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [37:0] w);
        {s_tdata, s_tkeep, s_tlast, s_tuser} = w;
    endtask

    function automatic logic [37:0] m_word();
        return {m_tdata, m_tkeep, m_tlast, m_tuser};
    endfunction

    // Scoreboarded traffic: pv/pr are the percent chances of tvalid/tready.
    // In strict mode the bench also requires tready high and no output bubbles.
    task automatic run_stream(input int n_words, input int pv, input int pr,
                              input bit strict, input int budget, input string tag);
        logic [37:0] q[$];
        logic [37:0] prev_word;
        logic [37:0] w;
        bit          prev_stall = 1'b0;
        bit          started    = 1'b0;
        int          wr_cnt     = 0;
        int          cyc        = 0;
        while ((wr_cnt < n_words || q.size() != 0) && cyc < budget) begin
            if (m_tvalid) begin
                started = 1'b1;
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, {63'd0, m_tvalid}, 64'd0);
                end else begin
                    check({tag, "_data"}, {26'd0, m_word()}, {26'd0, q[0]});
                end
                if (prev_stall) begin
                    check({tag, "_stable"}, {26'd0, m_word()}, {26'd0, prev_word});
                end
            end
            if (strict) begin
                check({tag, "_tready"}, {63'd0, s_tready}, 64'd1);
                if (started && q.size() != 0) begin
                    check({tag, "_bubble"}, {63'd0, m_tvalid}, 64'd1);
                end
            end
            s_tvalid = (wr_cnt < n_words) && ($urandom_range(99) < pv);
            m_tready = ($urandom_range(99) < pr);
            w = {$urandom, 4'($urandom), 1'($urandom), 1'($urandom)};
            drive(w);
            if (s_tvalid && s_tready) begin
                q.push_back(w);
                wr_cnt++;
            end
            if (m_tvalid && m_tready && q.size() != 0) begin
                void'(q.pop_front());
            end
            prev_stall = m_tvalid && !m_tready;
            prev_word  = m_word();
            step();
            cyc++;
        end
        if (cyc >= budget) begin
            check({tag, "_timeout_words_left"}, 64'(q.size()), 64'd0);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
    endtask

    vec_t vecs[15];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // {rstn, sv, d, k, l, u, mr,  e_sr, e_mv, chk, e_d, e_k, e_l, e_u}
        vecs[0]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0,  1, 0, 1, 32'h0,        4'h0, 0, 0};
        vecs[1]  = '{0, 1, 32'hdead,     4'hf, 1, 1, 1,  1, 0, 1, 32'h0,        4'h0, 0, 0};
        vecs[2]  = '{1, 1, 32'h1c100000, 4'h3, 1, 0, 0,  1, 0, 0, 32'h0,        4'h0, 0, 0};
        vecs[3]  = '{1, 0, 32'h0,        4'h0, 0, 0, 0,  1, 1, 1, 32'h1c100000, 4'h3, 1, 0};
        vecs[4]  = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 0, 0, 32'h0,        4'h0, 0, 0};
        vecs[5]  = '{1, 1, 32'h11,       4'h1, 0, 1, 0,  1, 0, 0, 32'h0,        4'h0, 0, 0};
        vecs[6]  = '{1, 1, 32'h22,       4'h2, 1, 0, 0,  1, 1, 1, 32'h11,       4'h1, 0, 1};
        vecs[7]  = '{1, 1, 32'h33,       4'h4, 0, 1, 0,  1, 1, 1, 32'h11,       4'h1, 0, 1};
        vecs[8]  = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 1, 32'h22,       4'h2, 1, 0};
        vecs[9]  = '{1, 1, 32'h44,       4'h8, 1, 1, 1,  1, 1, 1, 32'h33,       4'h4, 0, 1};
        vecs[10] = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 1, 32'h44,       4'h8, 1, 1};
        vecs[11] = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 0, 0, 32'h0,        4'h0, 0, 0};
        vecs[12] = '{1, 1, 32'h55,       4'hf, 0, 0, 1,  1, 0, 0, 32'h0,        4'h0, 0, 0};
        vecs[13] = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 1, 32'h55,       4'hf, 0, 0};
        vecs[14] = '{1, 0, 32'h0,        4'h0, 0, 0, 1,  1, 0, 0, 32'h0,        4'h0, 0, 0};

        rstn     = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        drive('0);
        step();

        // Table-driven: apply inputs, clock, check the post-edge outputs.
        for (int i = 0; i < 15; i++) begin
            rstn     = vecs[i].rstn;
            s_tvalid = vecs[i].sv;
            m_tready = vecs[i].mr;
            drive({vecs[i].d, vecs[i].k, vecs[i].l, vecs[i].u});
            step();
            check($sformatf("vec%0d_tready", i), {63'd0, s_tready}, {63'd0, vecs[i].e_sr});
            check($sformatf("vec%0d_tvalid", i), {63'd0, m_tvalid}, {63'd0, vecs[i].e_mv});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_word", i), {26'd0, m_word()},
                      {26'd0, vecs[i].e_d, vecs[i].e_k, vecs[i].e_l, vecs[i].e_u});
            end
        end

        // Fill to DEPTH+1 = 17 words with the consumer stalled.
        rstn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("fill%0d_tready", i), {63'd0, s_tready}, 64'd1);
            s_tvalid = 1'b1;
            drive({32'(i), 4'(i), (i == 16), 1'(i)});
            step();
        end
        s_tvalid = 1'b0;
        check("fill_full_tready", {63'd0, s_tready}, 64'd0);
`ifdef AXIS_SYNC_FIFO_STATUS_EN
        check("fill_status_count", {58'd0, status_count}, 64'd17);
`endif
        s_tvalid = 1'b1;
        drive({32'd99, 4'h0, 1'b0, 1'b0});
        step();
        s_tvalid = 1'b0;
        check("fill_extra_tready", {63'd0, s_tready}, 64'd0);
`ifdef AXIS_SYNC_FIFO_STATUS_EN
        check("fill_overflow", {63'd0, status_overflow}, 64'd1);
`endif
        m_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("drain%0d_tvalid", i), {63'd0, m_tvalid}, 64'd1);
            check($sformatf("drain%0d_word", i), {26'd0, m_word()},
                  {26'd0, 32'(i), 4'(i), (i == 16), 1'(i)});
            step();
        end
        check("drain_empty_tvalid", {63'd0, m_tvalid}, 64'd0);
        m_tready = 1'b0;

        // Continuous streaming, then 50% random backpressure.
        run_stream(1001, 100, 100, 1'b1, 1100, "stream");
        run_stream(10000, 50, 50, 1'b0, 60000, "random");

        // Reset with 5 words held.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            drive({32'h100 + 32'(i), 4'hf, 1'b0, 1'b0});
            step();
        end
        s_tvalid = 1'b0;
        rstn = 1'b0;
        step();
        check("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_min_tvalid", {63'd0, m_tvalid2}, 64'd0);
        check("rst_tready", {63'd0, s_tready}, 64'd1);
        rstn = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        drive({32'hA5, 4'h0, 1'b0, 1'b1});
        step();
        s_tvalid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (m_tvalid) found = 1'b1;
            else step();
        end
        check("post_rst_seen", {63'd0, found}, 64'd1);
        check("post_rst_word", {26'd0, m_word()}, {26'd0, 32'hA5, 4'h0, 1'b0, 1'b1});
        check("min_tvalid", {63'd0, m_tvalid2}, 64'd1);
        check("min_side", {26'd0, m_tdata2, m_tkeep2, m_tlast2, m_tuser2},
              {26'd0, 32'hA5, 4'hf, 1'b1, 1'b0});
        step();
        check("post_rst_empty", {63'd0, m_tvalid}, 64'd0);
        m_tready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
